img_loader: RTL and testbench

IMG_LOADER -- requirements
Module: img_loader

---
 rtl/img_loader.sv | 140 ++++++++++++++
 tb/tb_img_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/img_loader.sv
// Frame loader: streams 8-bit pixels into BRAM, then kicks the Sobel core and waits for it.
// Optional s_last framing check enabled by defining IMG_LOADER_LAST_CHECK_EN.
module img_loader #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [31:0] bram0_addr,
    output logic [31:0] bram0_din,
    output logic [3:0]  bram0_we,
    output logic        bram0_en,
    output logic        conv_start,
    input  logic        conv_done,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        FIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic          accept;
    logic          frame_begin;
    logic          last_beat;

    assign accept      = s_valid && s_ready;
    assign frame_begin = (state == IDLE) && load_start;
    assign last_beat   = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        conv_start = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && last_beat) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            RUN: begin
                conv_start = 1'b1;
                if (conv_done) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (frame_begin) begin
            idx <= '0;
        end else if (accept) begin
            idx <= idx + 1'b1;
        end
    end

    // The write port lags acceptance by one cycle; the address is left parked between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram0_en   <= 1'b0;
            bram0_we   <= 4'b0000;
            bram0_addr <= 32'd0;
            bram0_din  <= 32'd0;
        end else if (accept) begin
            bram0_en   <= 1'b1;
            bram0_we   <= 4'b1111;
            bram0_addr <= 32'({idx, 2'b00});
            bram0_din  <= {24'd0, s_data};
        end else begin
            bram0_en   <= 1'b0;
            bram0_we   <= 4'b0000;
            bram0_din  <= 32'd0;
        end
    end

`ifdef IMG_LOADER_LAST_CHECK_EN
    // Sticky: a misplaced or missing s_last is recorded but never shortens the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (frame_begin) begin
            err <= 1'b0;
        end else if (accept && (s_last != last_beat)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_img_loader.sv
// Randomized bench for img_loader on a 4x4 image, checked against a pixel-array model.
module tb_img_loader;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [31:0] bram0_addr;
    logic [31:0] bram0_din;
    logic [3:0]  bram0_we;
    logic        bram0_en;
    logic        conv_start;
    logic        conv_done;
    logic        busy;
    logic        frame_done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pix [N];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_din_q  [$];
    logic [31:0] last_addr;

    img_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .bram0_addr (bram0_addr),
        .bram0_din  (bram0_din),
        .bram0_we   (bram0_we),
        .bram0_en   (bram0_en),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, s_ready, 0);
        checkOutput({tag, "_en"}, bram0_en, 0);
        checkOutput({tag, "_we"}, bram0_we, 0);
        checkOutput({tag, "_addr"}, bram0_addr, 0);
        checkOutput({tag, "_din"}, bram0_din, 0);
        checkOutput({tag, "_conv"}, conv_start, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, frame_done, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    // Every write seen on the BRAM port is logged; idle cycles must be quiet with a parked address.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = 32'd0;
        end else if (bram0_en) begin
            wr_addr_q.push_back(bram0_addr);
            wr_din_q.push_back(bram0_din);
            checkOutput("wr_we", bram0_we, 4'hf);
            last_addr = bram0_addr;
        end else begin
            checkOutput("idle_we", bram0_we, 0);
            checkOutput("idle_din", bram0_din, 0);
            checkOutput("hold_addr", bram0_addr, last_addr);
        end
    end

    task automatic fillPixels(input bit ramp);
        for (int i = 0; i < N; i++) begin
            pix[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
        end
    endtask

    task automatic startFrame();
        wr_addr_q.delete();
        wr_din_q.delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checkOutput("load_ready", s_ready, 1);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_err", err, 0);
    endtask

    // gap < 0 picks a random 0..3 idle cycles before each beat; last_beat < 0 means no s_last at all.
    task automatic applyStimulus(input int gap, input bit noise, input int last_beat, input int run_len);
        int  gaps;
        int  hi;
        bit  exp_err;
        exp_err = 1'b0;
`ifdef IMG_LOADER_LAST_CHECK_EN
        exp_err = (last_beat != N - 1);
`endif
        startFrame();
        for (int i = 0; i < N; i++) begin
            gaps = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int g = 0; g < gaps; g++) begin
                s_valid = 1'b0;
                if (noise) begin
                    load_start = 1'($urandom_range(0, 1));
                    conv_done  = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                load_start = 1'b0;
                conv_done  = 1'b0;
                checkOutput("gap_ready", s_ready, 1);
            end
            checkOutput("beat_ready", s_ready, 1);
            s_valid = 1'b1;
            s_data  = pix[i];
            s_last  = (i == last_beat);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("flush_en", bram0_en, 1);
        checkOutput("flush_addr", bram0_addr, 32'((N - 1) * 4));
        checkOutput("flush_din", bram0_din, {24'd0, pix[N-1]});
        checkOutput("flush_ready", s_ready, 0);
        checkOutput("flush_conv", conv_start, 0);
        @(negedge clk);
        checkOutput("run_first_conv", conv_start, 1);
        hi = 0;
        for (int c = 0; c < run_len; c++) begin
            if (conv_start) hi++;
            checkOutput("run_done", frame_done, 0);
            if (c == run_len - 1) conv_done = 1'b1;
            @(negedge clk);
        end
        conv_done = 1'b0;
        checkOutput("conv_high_cycles", hi, run_len);
        checkOutput("fin_done", frame_done, 1);
        checkOutput("fin_conv", conv_start, 0);
        checkOutput("fin_busy", busy, 1);
        checkOutput("fin_err", err, exp_err);
        @(negedge clk);
        checkOutput("idle_frame_done", frame_done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_err", err, exp_err);
        checkOutput("wr_count", wr_addr_q.size(), N);
        for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
            checkOutput("wr_addr", wr_addr_q[i], 32'(i * 4));
            checkOutput("wr_din", wr_din_q[i], {24'd0, pix[i]});
        end
        @(negedge clk);
        checkOutput("idle_err_sticky", err, exp_err);
    endtask

    task automatic partialFrame(input int beats);
        startFrame();
        for (int i = 0; i < beats; i++) begin
            s_valid = 1'b1;
            s_data  = pix[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        checkOutput("pre_rst_en", bram0_en, 1);
        checkOutput("pre_rst_addr", bram0_addr, 32'((beats - 1) * 4));
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("post_rst");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'd0;
        s_last     = 1'b0;
        conv_done  = 1'b0;
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("after_reset");

        fillPixels(1'b1);
        applyStimulus(0, 1'b0, N - 1, 5);

        fillPixels(1'b0);
        applyStimulus(3, 1'b0, N - 1, 50);

        fillPixels(1'b0);
        applyStimulus(-1, 1'b1, N - 1, int'($urandom_range(1, 10)));

        fillPixels(1'b0);
        applyStimulus(0, 1'b0, 9, 3);

        fillPixels(1'b0);
        applyStimulus(-1, 1'b0, N - 1, 2);

        fillPixels(1'b0);
        partialFrame(8);
        fillPixels(1'b0);
        applyStimulus(0, 1'b0, N - 1, 4);

        fillPixels(1'b0);
        applyStimulus(1, 1'b1, -1, 1);

        fillPixels(1'b0);
        applyStimulus(-1, 1'b1, N - 1, int'($urandom_range(1, 20)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
